// File: rtl/trans_phase_driver_pkg.sv
// Shared opcodes, parser states and phase arithmetic for the ultrasonic
// transducer phase driver.
package trans_pkg;

    localparam logic [7:0] OP_SET_PHASE = 8'h01;
    localparam logic [7:0] OP_COMMIT    = 8'h02;
    localparam logic [7:0] OP_ENABLE    = 8'h03;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHAN   = 3'd1,
        PH_HI  = 3'd2,
        PH_LO  = 3'd3,
        EN_ARG = 3'd4
    } parse_state_e;

    // Distance of the counter past a channel's phase point, modulo the period.
    function automatic logic [16:0] phase_offset(
        input logic [16:0] cnt,
        input logic [16:0] act,
        input logic [16:0] period
    );
        return (cnt >= act) ? (cnt - act) : (cnt + period - act);
    endfunction

endpackage

// File: rtl/trans_phase_driver_sync.sv
// Two-flop synchroniser for the external sync input with a registered
// one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            meta_q     <= async_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
            rise_q     <= sync_q & ~sync_dly_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/trans_phase_driver.sv
// Multi-channel transducer driver: byte-command parser, double-buffered
// per-channel phases and a shared carrier period counter.
//
// state  | meaning
// IDLE   | waiting for an opcode byte
// CHAN   | next byte is the channel index
// PH_HI  | next byte is phase[15:8]
// PH_LO  | next byte is phase[7:0], then range check and shadow write
// EN_ARG | next byte bit 0 is the new enable
module trans_phase_driver
    import trans_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int PERIOD       = 1250,
    parameter int SYNC_SLAVE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              cmd_data,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    sync_in,
    output logic                    sync_out,
    output logic [NUM_CHANNELS-1:0] trans,
    output logic                    cmd_err
);

    localparam int              PW       = $clog2(PERIOD);
    localparam int              CW       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [PW-1:0]   CNT_LAST = PW'(PERIOD - 1);
    localparam logic [16:0]     PERIOD_X = 17'(PERIOD);
    localparam logic [16:0]     HALF_X   = 17'(PERIOD / 2);

    parse_state_e              state_q;
    logic [7:0]                chan_q;
    logic [7:0]                ph_hi_q;
    logic                      enable_q;
    logic                      enable_d;
    logic                      cmd_err_q;
    logic                      cmd_ready_q;
    logic                      pending_q;
    logic                      pending_d;
    logic [PW-1:0]             cnt_q;
    logic [PW-1:0]             cnt_d;
    logic                      start_q;
    logic                      start_d;
    logic                      sync_out_q;
    logic [NUM_CHANNELS-1:0]   trans_q;
    logic [NUM_CHANNELS-1:0]   trans_d;
    logic [PW-1:0]             shadow_q [NUM_CHANNELS];
    logic [PW-1:0]             active_q [NUM_CHANNELS];

    logic                      accept;
    logic                      commit_cmd;
    logic                      sync_rise;
    logic                      realign;
    logic [15:0]               phase_w;
    logic                      phase_ok;
    logic                      chan_ok;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (sync_in),
        .rise_o  (sync_rise)
    );

    assign phase_w  = {ph_hi_q, cmd_data};
    assign phase_ok = (32'(phase_w) < 32'(PERIOD));
    assign chan_ok  = (32'(chan_q) < 32'(NUM_CHANNELS));

    always_comb begin
        accept     = cmd_valid && cmd_ready_q;
        commit_cmd = accept && (state_q == IDLE) && (cmd_data == OP_COMMIT);

        enable_d = enable_q;
        if (accept && (state_q == EN_ARG)) begin
            enable_d = cmd_data[0];
        end

        realign = (SYNC_SLAVE != 0) && sync_rise;
        if (realign || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
        // A realign landing on a counter that is already at 0 is not a new period.
        start_d = (cnt_d == '0) && (cnt_q != '0);

        pending_d = pending_q;
        if (start_d) begin
            pending_d = 1'b0;
        end
        if (commit_cmd) begin
            pending_d = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [16:0] offset;
        assign offset     = phase_offset(17'(cnt_q), 17'(active_q[g]), PERIOD_X);
        assign trans_d[g] = enable_d && (offset < HALF_X);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            ph_hi_q   <= '0;
            enable_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            cmd_err_q <= 1'b0;
            enable_q  <= enable_d;
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (cmd_data == OP_SET_PHASE) begin
                            state_q <= CHAN;
                        end else if (cmd_data == OP_ENABLE) begin
                            state_q <= EN_ARG;
                        end else if (cmd_data != OP_COMMIT) begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                    CHAN: begin
                        chan_q  <= cmd_data;
                        state_q <= PH_HI;
                    end
                    PH_HI: begin
                        ph_hi_q <= cmd_data;
                        state_q <= PH_LO;
                    end
                    PH_LO: begin
                        if (chan_ok && phase_ok) begin
                            shadow_q[chan_q[CW-1:0]] <= phase_w[PW-1:0];
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    EN_ARG: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // start_q resets high so the first cycle out of reset counts as a period start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            start_q     <= 1'b1;
            sync_out_q  <= 1'b0;
            pending_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            trans_q     <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                active_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            sync_out_q  <= start_q;
            pending_q   <= pending_d;
            cmd_ready_q <= !pending_d;
            trans_q     <= trans_d;
            if (start_d && pending_q) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign sync_out  = sync_out_q;
    assign trans     = trans_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_trans_phase_driver.sv
// Bench for trans_phase_driver: table-driven command vectors, directed
// timing sequences and random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_trans_phase_driver;

    localparam int P   = 1250;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     cmd_data = 8'h00;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           sync_in = 1'b0;
    logic           sync_out;
    logic [NCH-1:0] trans;
    logic           cmd_err;

    always #10 clk = ~clk;

    trans_phase_driver #(
        .NUM_CHANNELS (NCH),
        .PERIOD       (P),
        .SYNC_SLAVE   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .sync_in   (sync_in),
        .sync_out  (sync_out),
        .trans     (trans),
        .cmd_err   (cmd_err)
    );

    int checks = 0;
    int errors = 0;
    int shown  = 0;

    // Behavioural model: counter position, phase tables and a byte queue for
    // the command being assembled.
    int             m_cnt;
    bit             m_start_prev;
    int             m_shadow [NCH];
    int             m_active [NCH];
    bit             m_en;
    bit             m_pending;
    byte unsigned   m_cmd [$];
    bit [3:0]       m_hist;
    bit             m_acc_last;
    bit [NCH-1:0]   e_trans;
    bit             e_sync;
    bit             e_ready;
    bit             e_err;

    function automatic void model_reset();
        m_cnt        = 0;
        m_start_prev = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        m_en       = 1'b0;
        m_pending  = 1'b0;
        m_cmd.delete();
        m_hist     = '0;
        m_acc_last = 1'b0;
        e_trans    = '0;
        e_sync     = 1'b0;
        e_ready    = 1'b0;
        e_err      = 1'b0;
    endfunction

    function automatic void model_step();
        bit realign, start, accept, err, commit_now, en_new;
        int next_cnt, ch, ph;
        // a pin edge sampled three clocks ago realigns now
        realign  = m_hist[2] & ~m_hist[3];
        m_hist   = {m_hist[2:0], sync_in};
        accept   = cmd_valid && e_ready;
        next_cnt = (realign || m_cnt == P - 1) ? 0 : m_cnt + 1;
        start    = (next_cnt == 0) && (m_cnt != 0);
        err = 1'b0; commit_now = 1'b0; en_new = m_en;
        if (accept) begin
            m_cmd.push_back(cmd_data);
            case (m_cmd[0])
                8'h01: if (m_cmd.size() == 4) begin
                    ch = m_cmd[1];
                    ph = m_cmd[2] * 256 + m_cmd[3];
                    if (ch < NCH && ph < P) m_shadow[ch] = ph;
                    else err = 1'b1;
                    m_cmd.delete();
                end
                8'h02: begin
                    commit_now = 1'b1;
                    m_cmd.delete();
                end
                8'h03: if (m_cmd.size() == 2) begin
                    en_new = (m_cmd[1] % 2) == 1;
                    m_cmd.delete();
                end
                default: begin
                    err = 1'b1;
                    m_cmd.delete();
                end
            endcase
        end
        for (int i = 0; i < NCH; i++) begin
            e_trans[i] = en_new && (((m_cnt - m_active[i] + P) % P) < P / 2);
        end
        e_sync       = m_start_prev;
        m_start_prev = start;
        if (start && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (commit_now) m_pending = 1'b1;
        e_ready    = !m_pending;
        e_err      = err;
        m_en       = en_new;
        m_cnt      = next_cnt;
        m_acc_last = accept;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (shown < 30) $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
            shown++;
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        chk("trans",     int'(trans),     int'(e_trans));
        chk("sync_out",  int'(sync_out),  int'(e_sync));
        chk("cmd_ready", int'(cmd_ready), int'(e_ready));
        chk("cmd_err",   int'(cmd_err),   int'(e_err));
    end

    // Called just after a negedge; returns on the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = b;
        do begin
            @(negedge clk);
            n++;
        end while (!m_acc_last && n < 3 * P);
        if (!m_acc_last) timeout("send_byte");
        cmd_valid = 1'b0;
    endtask

    task automatic set_phase(input int ch, input int ph);
        send_byte(8'h01);
        send_byte(8'(ch));
        send_byte(8'(ph >> 8));
        send_byte(8'(ph & 255));
    endtask

    task automatic wait_sync(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sync_out && n < 3 * P);
        if (!sync_out) timeout(name);
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (m_cnt != v && n < 2 * P) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != v) timeout("wait_cnt");
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic        exp_err;
        string       name;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int n, mism, prev0;
        logic [31:0] w;

        vecs[0] = '{32'h5500_0000, 1, 1'b1, "bad_opcode"};
        vecs[1] = '{32'h0107_0010, 4, 1'b1, "chan_7"};
        vecs[2] = '{32'h0104_0005, 4, 1'b1, "chan_eq_num"};
        vecs[3] = '{32'h0101_04E2, 4, 1'b1, "phase_eq_period"};
        vecs[4] = '{32'h0102_04E1, 4, 1'b0, "phase_max"};
        vecs[5] = '{32'h0103_0000, 4, 1'b0, "phase_zero"};
        vecs[6] = '{32'h0000_0000, 1, 1'b1, "op_zero"};
        vecs[7] = '{32'h0301_0000, 2, 1'b0, "enable_on"};
        vecs[8] = '{32'h0300_0000, 2, 1'b0, "enable_off"};
        vecs[9] = '{32'h0100_FFFF, 4, 1'b1, "phase_ffff"};

        repeat (3) @(negedge clk);
        chk("rst_trans",    int'(trans),     0);
        chk("rst_sync_out", int'(sync_out),  0);
        chk("rst_ready",    int'(cmd_ready), 0);
        chk("rst_err",      int'(cmd_err),   0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", int'(cmd_ready), 1);

        for (int i = 0; i < NV; i++) begin
            w = vecs[i].bytes;
            for (int k = 0; k < vecs[i].n; k++) send_byte(w[31 - 8 * k -: 8]);
            chk(vecs[i].name, int'(cmd_err), int'(vecs[i].exp_err));
            @(negedge clk);
            chk("err_one_cycle", int'(cmd_err), 0);
        end

        send_byte(8'h55);
        chk("b2b_err_first", int'(cmd_err), 1);
        send_byte(8'hAA);
        chk("b2b_err_second", int'(cmd_err), 1);
        @(negedge clk);

        // ch1 half a period behind ch0: outputs in antiphase
        set_phase(1, 625);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h01);
        prev0 = int'(trans[0]);
        n = 0;
        while (n < 3 * P) begin
            @(negedge clk);
            n++;
            if (sync_out) break;
            prev0 = int'(trans[0]);
        end
        if (!sync_out) timeout("sync_after_enable");
        chk("ph0_low_before_sync", prev0, 0);
        chk("ph0_rise_with_sync", int'(trans[0]), 1);
        mism = 0;
        for (int i = 0; i < P; i++) begin
            if (trans[1] == trans[0]) mism++;
            @(negedge clk);
        end
        chk("antiphase_mismatches", mism, 0);

        // staged phase stays invisible until commit
        set_phase(0, 300);
        chk("ready_while_staged", int'(cmd_ready), 1);
        wait_sync("sync_staged", n);
        chk("old_phase_kept", int'(trans[0]), 1);
        send_byte(8'h02);
        chk("ready_low_pending", int'(cmd_ready), 0);
        wait_sync("sync_commit", n);
        chk("new_phase_low_at_start", int'(trans[0]), 0);
        chk("ready_after_swap", int'(cmd_ready), 1);
        n = 0;
        while (!trans[0] && n < P) begin
            @(negedge clk);
            n++;
        end
        chk("rise_delay_300", n, 300);

        // external realign mid-period
        wait_cnt(400);
        sync_in = 1'b1;
        wait_sync("sync_realign", n);
        chk("realign_latency", n, 5);
        wait_sync("sync_after_realign", n);
        chk("period_after_realign", n, P);
        sync_in = 1'b0;

        // edge landing exactly on the natural wrap
        wait_cnt(P - 4);
        sync_in = 1'b1;
        wait_sync("sync_coincident", n);
        chk("coincident_latency", n, 5);
        sync_in = 1'b0;
        wait_sync("sync_after_coincident", n);
        chk("coincident_period", n, P);

        // edge landing one cycle after the wrap: counter holds 0 one extra cycle
        wait_cnt(P - 3);
        sync_in = 1'b1;
        wait_sync("sync_late", n);
        chk("late_latency", n, 4);
        sync_in = 1'b0;
        wait_sync("sync_after_late", n);
        chk("late_period", n, P + 1);

        for (int r = 0; r < 40; r++) begin
            int kind;
            kind = int'($urandom_range(0, 19));
            if (kind < 11) begin
                set_phase(int'($urandom_range(0, 5)), int'($urandom_range(0, 1300)));
            end else if (kind < 15) begin
                send_byte(8'h02);
            end else if (kind < 18) begin
                send_byte(8'h03);
                send_byte(($urandom_range(0, 3) != 0) ? 8'h01 : 8'h00);
            end else begin
                send_byte(8'($urandom_range(4, 255)));
            end
            if ($urandom_range(0, 7) == 0) sync_in = ~sync_in;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        sync_in = 1'b0;
        send_byte(8'h02);
        repeat (2 * P) @(negedge clk);

        // reset in the middle of a SET_PHASE command
        send_byte(8'h01);
        send_byte(8'h02);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_trans",    int'(trans),     0);
        chk("midrst_sync_out", int'(sync_out),  0);
        chk("midrst_ready",    int'(cmd_ready), 0);
        chk("midrst_err",      int'(cmd_err),   0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h00);
        chk("post_rst_ph_hi_is_opcode", int'(cmd_err), 1);
        send_byte(8'h64);
        chk("post_rst_ph_lo_is_opcode", int'(cmd_err), 1);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
